platform_scheduler: RTL

// - Owns the platform table drawn by the colour mapper: PLAT_N slots, each with an X and Y position.
// - Once per frame it scrolls every platform down when the doodle climbs above SCROLL_LINE.
// - A platform that falls off the bottom respawns at the top with a fresh pseudo-random X.
// - Sits between the ball motion logic (BallY in) and color_mapper (packed plat_x/plat_y out).

---
 rtl/platform_pkg.sv | 12 +
 rtl/plat_lfsr.sv | 18 +
 rtl/platform_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/platform_pkg.sv
// Shared types and constants for the platform scheduler and its LFSR.
package platform_pkg;

    localparam int          PLAT_W           = 10;
    localparam int          PLAT_N_DEF       = 16;
    localparam int          PLAT_SPACING_DEF = 30;
    localparam int          WRAP_Y           = PLAT_N_DEF * PLAT_SPACING_DEF;
    localparam logic [15:0] LFSR_SEED        = 16'hACE1;

    typedef enum logic [2:0] {INIT, IDLE, CALC, UPDATE, DONE} state_t;

endpackage

// File: rtl/plat_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying respawn X positions.
module plat_lfsr
    import platform_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        en,
    output logic [15:0] q
);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            q <= LFSR_SEED;
        else if (en)
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    end

endmodule

// File: rtl/platform_scheduler.sv
// Platform table owner: init, per-frame scroll and respawn of PLAT_N slots.
// Optional PLATFORM_SCORE_EN builds a saturating score accumulator.
module platform_scheduler
    import platform_pkg::*;
#(
    parameter int PLAT_N       = PLAT_N_DEF,
    parameter int PLAT_SPACING = PLAT_SPACING_DEF,
    parameter int Y_OFFSET     = 15,
    parameter int X_MIN        = 4,
    parameter int SCROLL_LINE  = 200,
    parameter int MAX_SCROLL   = 15
)(
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     frame_clk,
    input  logic [PLAT_W-1:0]        BallY,
    output logic [PLAT_N*PLAT_W-1:0] plat_x,
    output logic [PLAT_N*PLAT_W-1:0] plat_y,
    output logic                     plat_valid,
    output logic [PLAT_W-1:0]        scroll_dy,
    output logic                     frame_done,
    output logic                     overrun,
    output logic [15:0]              score
);

    localparam int             IDX_W    = $clog2(PLAT_N);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PLAT_N - 1);

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic                fclk_q;
    logic [PLAT_W-1:0]   x_q [PLAT_N];
    logic [PLAT_W-1:0]   y_q [PLAT_N];
    logic                valid_q, done_q, ovr_q;
    logic [PLAT_W-1:0]   dy_q;
    logic [15:0]         lfsr_q;
    logic                lfsr_unused;

    logic                fe;
    logic [PLAT_W-1:0]   dy_d, spawn_x_d, init_y_d;
    logic [PLAT_W:0]     yn_d;

    plat_lfsr u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .en    (1'b1),
        .q     (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q[15:9];
    assign fe          = frame_clk & ~fclk_q;
    assign spawn_x_d   = PLAT_W'(X_MIN) + {1'b0, lfsr_q[8:0]};
    assign init_y_d    = PLAT_W'(int'(idx_q) * PLAT_SPACING + Y_OFFSET);
    assign yn_d        = {1'b0, y_q[idx_q]} + {1'b0, dy_q};

    always_comb begin
        dy_d = '0;
        if (BallY < PLAT_W'(SCROLL_LINE)) begin
            dy_d = PLAT_W'(SCROLL_LINE) - BallY;
            if (dy_d > PLAT_W'(MAX_SCROLL))
                dy_d = PLAT_W'(MAX_SCROLL);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= INIT;
            idx_q   <= '0;
            fclk_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            dy_q    <= '0;
            for (int i = 0; i < PLAT_N; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            fclk_q <= frame_clk;
            done_q <= 1'b0;
            // Edges that land outside IDLE are dropped, only remembered here.
            if (fe && state_q != IDLE)
                ovr_q <= 1'b1;
            case (state_q)
                INIT: begin
                    x_q[idx_q] <= spawn_x_d;
                    y_q[idx_q] <= init_y_d;
                    idx_q      <= idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        valid_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                IDLE: if (fe) state_q <= CALC;
                CALC: begin
                    dy_q    <= dy_d;
                    valid_q <= 1'b0;
                    idx_q   <= '0;
                    state_q <= (dy_d == '0) ? DONE : UPDATE;
                end
                UPDATE: begin
                    if (yn_d >= (PLAT_W+1)'(WRAP_Y)) begin
                        y_q[idx_q] <= PLAT_W'(yn_d - (PLAT_W+1)'(WRAP_Y));
                        x_q[idx_q] <= spawn_x_d;
                    end else begin
                        y_q[idx_q] <= yn_d[PLAT_W-1:0];
                    end
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == IDX_LAST)
                        state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b1;
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < PLAT_N; i++) begin : g_flat
        assign plat_x[i*PLAT_W +: PLAT_W] = x_q[i];
        assign plat_y[i*PLAT_W +: PLAT_W] = y_q[i];
    end

    assign plat_valid = valid_q;
    assign scroll_dy  = dy_q;
    assign frame_done = done_q;
    assign overrun    = ovr_q;

`ifdef PLATFORM_SCORE_EN
    logic [15:0] score_q;
    logic [16:0] score_sum_d;

    assign score_sum_d = {1'b0, score_q} + 17'(dy_d);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            score_q <= '0;
        else if (state_q == CALC)
            score_q <= score_sum_d[16] ? 16'hFFFF : score_sum_d[15:0];
    end

    assign score = score_q;
`else
    assign score = 16'h0000;
`endif

endmodule
